// File: rtl/fft_iter.sv
// Iterative in-place radix-2 DIT FFT/IFFT over POINTS complex samples; define FFT_STAGE_SCALE_EN for a 1/2 shift per stage.
// Latency: POINTS load cycles, (POINTS/2)*log2(POINTS) butterfly cycles, then POINTS result beats.
// Backpressure: in_ready only in LOAD; results hold stable while out_valid && !out_ready.
module fft_iter #(
    parameter int POINTS = 8,
    parameter int DATA_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_real,
    input  logic [DATA_W-1:0]         in_imag,
    input  logic                      inverse,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_real,
    output logic [DATA_W-1:0]         out_imag,
    output logic [$clog2(POINTS)-1:0] out_index,
    output logic                      busy
);

    localparam int LOGN = $clog2(POINTS);
    localparam int BW   = LOGN - 1;
    localparam int PW   = DATA_W + 18;
    localparam logic [LOGN-1:0]        CNT_LAST = LOGN'(POINTS - 1);
    localparam logic [LOGN-1:0]        STG_LAST = LOGN'(LOGN - 1);
    localparam logic signed [PW-1:0]   RND      = PW'(8192);

    typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_UNLOAD} state_t;

    state_t state, state_n;

    logic [DATA_W-1:0] mem_re [POINTS];
    logic [DATA_W-1:0] mem_im [POINTS];

    logic [LOGN-1:0] cnt;
    logic [LOGN-1:0] stage;
    logic [BW-1:0]   bfly;
    logic            inv_q;
    logic            last_bfly;

    logic [LOGN-1:0] half, pos, top, bot;
    logic [4:0]      tw_m;

    logic signed [15:0]       w_re, w_im, w_sin;
    logic signed [PW-1:0]     ar_x, ai_x, br_x, bi_x, wr_x, wi_x;
    logic signed [PW-1:0]     p_re, p_im, t_re, t_im, s_re, s_im, d_re, d_im;
    logic [DATA_W-1:0]        top_re_n, top_im_n, bot_re_n, bot_im_n;

    function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] a);
        logic [LOGN-1:0] r;
        for (int i = 0; i < LOGN; i++) r[i] = a[LOGN-1-i];
        return r;
    endfunction

    // Quarter-wave of round(16384*cos(2*pi*i/32)); the full circle is folded onto it.
    function automatic logic signed [15:0] qcos(input logic [3:0] i);
        case (i)
            4'd0:    return 16'sd16384;
            4'd1:    return 16'sd16069;
            4'd2:    return 16'sd15137;
            4'd3:    return 16'sd13623;
            4'd4:    return 16'sd11585;
            4'd5:    return 16'sd9102;
            4'd6:    return 16'sd6270;
            4'd7:    return 16'sd3196;
            default: return 16'sd0;
        endcase
    endfunction

    assign last_bfly = (stage == STG_LAST) && (bfly == '1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_LOAD;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && cnt == CNT_LAST) state_n = S_COMPUTE;
            end
            S_COMPUTE: begin
                busy = 1'b1;
                if (last_bfly) state_n = S_UNLOAD;
            end
            S_UNLOAD: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready && cnt == CNT_LAST) state_n = S_LOAD;
            end
            default: state_n = S_LOAD;
        endcase
    end

    // cnt serves as load address in LOAD and result index in UNLOAD; both end wrapped to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            stage <= '0;
            bfly  <= '0;
            inv_q <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (in_valid) begin
                        cnt <= cnt + LOGN'(1);
                        if (cnt == '0) inv_q <= inverse;
                    end
                end
                S_COMPUTE: begin
                    bfly <= bfly + BW'(1);
                    if (bfly == '1) stage <= (stage == STG_LAST) ? '0 : stage + LOGN'(1);
                end
                S_UNLOAD: begin
                    if (out_ready) cnt <= cnt + LOGN'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        half = LOGN'(1) << stage;
        pos  = LOGN'(bfly) & (half - LOGN'(1));
        top  = (((LOGN'(bfly) >> stage) << stage) << 1) | pos;
        bot  = top | half;
        tw_m = 5'(pos) << (3'd4 - 3'(stage));
    end

    always_comb begin
        if (tw_m <= 5'd8) begin
            w_re  = qcos(tw_m[3:0]);
            w_sin = qcos(4'(5'd8 - tw_m));
        end else begin
            w_re  = -qcos(4'(5'd16 - tw_m));
            w_sin = qcos(4'(tw_m - 5'd8));
        end
        w_im = inv_q ? w_sin : -w_sin;
    end

    assign ar_x = PW'($signed(mem_re[top]));
    assign ai_x = PW'($signed(mem_im[top]));
    assign br_x = PW'($signed(mem_re[bot]));
    assign bi_x = PW'($signed(mem_im[bot]));
    assign wr_x = PW'(w_re);
    assign wi_x = PW'(w_im);

    assign p_re = br_x * wr_x - bi_x * wi_x + RND;
    assign p_im = br_x * wi_x + bi_x * wr_x + RND;
    assign t_re = p_re >>> 14;
    assign t_im = p_im >>> 14;
    assign s_re = ar_x + t_re;
    assign s_im = ai_x + t_im;
    assign d_re = ar_x - t_re;
    assign d_im = ai_x - t_im;

`ifdef FFT_STAGE_SCALE_EN
    assign top_re_n = DATA_W'(s_re >>> 1);
    assign top_im_n = DATA_W'(s_im >>> 1);
    assign bot_re_n = DATA_W'(d_re >>> 1);
    assign bot_im_n = DATA_W'(d_im >>> 1);
`else
    assign top_re_n = DATA_W'(s_re);
    assign top_im_n = DATA_W'(s_im);
    assign bot_re_n = DATA_W'(d_re);
    assign bot_im_n = DATA_W'(d_im);
`endif

    always_ff @(posedge clk) begin
        if (state == S_LOAD && in_valid) begin
            mem_re[bitrev(cnt)] <= in_real;
            mem_im[bitrev(cnt)] <= in_imag;
        end else if (state == S_COMPUTE) begin
            mem_re[top] <= top_re_n;
            mem_im[top] <= top_im_n;
            mem_re[bot] <= bot_re_n;
            mem_im[bot] <= bot_im_n;
        end
    end

    assign out_real  = out_valid ? mem_re[cnt] : '0;
    assign out_imag  = out_valid ? mem_im[cnt] : '0;
    assign out_index = out_valid ? cnt : '0;

endmodule

// File: tb/tb_fft_iter.sv
// Randomised bench for fft_iter (POINTS=8, DATA_W=16) against an integer FFT reference.
module tb_fft_iter;

    localparam int  PTS = 8;
    localparam real PI  = 3.14159265358979;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, inverse, out_ready, out_valid, busy;
    logic [15:0] in_real, in_imag, out_real, out_imag;
    logic [2:0]  out_index;

    int checks = 0;
    int errors = 0;
    int in_re[PTS], in_im[PTS], exp_re[PTS], exp_im[PTS], got_re[PTS], got_im[PTS];

    fft_iter #(.POINTS(PTS), .DATA_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_real(in_real), .in_imag(in_imag), .inverse(inverse),
        .out_ready(out_ready), .out_valid(out_valid), .out_real(out_real),
        .out_imag(out_imag), .out_index(out_index), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input int obs, input int expv, input int tol = 0);
        int d;
        checks++;
        d = obs - expv;
        if (d < 0) d = -d;
        if (d > tol) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int rnd(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
    endfunction

    function automatic int wrap16(input longint v);
        logic signed [15:0] t;
        t = v[15:0];
        return int'(t);
    endfunction

    // Textbook decimation-in-time FFT on integer arrays with the block's rounding/wrap rules.
    task automatic ref_fft(input bit inv);
        int ar[PTS], ai[PTS];
        for (int n = 0; n < PTS; n++) begin
            int r = 0;
            for (int i = 0; i < 3; i++) r |= ((n >> i) & 1) << (2 - i);
            ar[r] = in_re[n];
            ai[r] = in_im[n];
        end
        for (int s = 0; s < 3; s++) begin
            int half = 1 << s;
            for (int j = 0; j < PTS; j += 2 * half) begin
                for (int p = 0; p < half; p++) begin
                    int k, wr, ws, wi, a, b;
                    longint tr, ti, sr, si, dr, di;
                    k  = p * (PTS / (2 * half));
                    wr = rnd(16384.0 * $cos(2.0 * PI * k / PTS));
                    ws = rnd(16384.0 * $sin(2.0 * PI * k / PTS));
                    wi = inv ? ws : -ws;
                    a  = j + p;
                    b  = a + half;
                    tr = (longint'(ar[b]) * wr - longint'(ai[b]) * wi + 8192) >>> 14;
                    ti = (longint'(ar[b]) * wi + longint'(ai[b]) * wr + 8192) >>> 14;
                    sr = ar[a] + tr; si = ai[a] + ti;
                    dr = ar[a] - tr; di = ai[a] - ti;
`ifdef FFT_STAGE_SCALE_EN
                    sr = sr >>> 1; si = si >>> 1; dr = dr >>> 1; di = di >>> 1;
`endif
                    ar[a] = wrap16(sr); ai[a] = wrap16(si);
                    ar[b] = wrap16(dr); ai[b] = wrap16(di);
                end
            end
        end
        for (int n = 0; n < PTS; n++) begin
            exp_re[n] = ar[n];
            exp_im[n] = ai[n];
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_in_ready"},  int'(in_ready), 1);
        check({tag, "_out_valid"}, int'(out_valid), 0);
        check({tag, "_busy"},      int'(busy), 0);
        check({tag, "_out_real"},  int'(out_real), 0);
        check({tag, "_out_imag"},  int'(out_imag), 0);
        check({tag, "_out_index"}, int'(out_index), 0);
    endtask

    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        check_idle(tag);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_frame(input bit inv, input bit toggle, input bit wait_out);
        int n;
        for (int i = 0; i < PTS; i++) begin
            n = 0;
            while (!in_ready && n < 100) begin
                @(posedge clk); n++; @(negedge clk);
            end
            check("load_in_ready", int'(in_ready), 1);
            check("load_out_valid", int'(out_valid), 0);
            in_valid = 1'b1;
            in_real  = 16'(in_re[i]);
            in_imag  = 16'(in_im[i]);
            inverse  = (i == 0 || !toggle) ? inv : 1'($urandom);
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (wait_out) begin
            n = 0;
            in_valid = 1'b1;
            while (!out_valid && n < 200) begin
                in_real = 16'($urandom);
                in_imag = 16'($urandom);
                inverse = 1'($urandom);
                check("compute_in_ready", int'(in_ready), 0);
                @(posedge clk); n++; @(negedge clk);
            end
            in_valid = 1'b0;
            check("ov_rise", int'(out_valid), 1);
            check("lat_cycle", n + 1, 13);
        end
    endtask

    task automatic recv(input int stall_bin);
        int n, hr, hi;
        for (int b = 0; b < PTS; b++) begin
            n = 0;
            while (!out_valid && n < 200) begin
                @(posedge clk); n++; @(negedge clk);
            end
            check("unload_ov", int'(out_valid), 1);
            if (!out_valid) return;
            check("unload_idx", int'(out_index), b);
            check("unload_in_ready", int'(in_ready), 0);
            check("unload_busy", int'(busy), 1);
            if (b == stall_bin) begin
                hr = int'($signed(out_real));
                hi = int'($signed(out_imag));
                out_ready = 1'b0;
                repeat (5) begin
                    @(posedge clk); @(negedge clk);
                    check("hold_idx", int'(out_index), b);
                    check("hold_re", int'($signed(out_real)), hr);
                    check("hold_im", int'($signed(out_imag)), hi);
                    check("hold_ov", int'(out_valid), 1);
                    check("hold_in_ready", int'(in_ready), 0);
                end
                out_ready = 1'b1;
            end
            got_re[b] = int'($signed(out_real));
            got_im[b] = int'($signed(out_imag));
            @(posedge clk);
            @(negedge clk);
        end
        check("done_in_ready", int'(in_ready), 1);
        check("done_out_valid", int'(out_valid), 0);
    endtask

    task automatic run_frame(input string tag, input bit inv, input bit toggle, input int stall_bin);
        ref_fft(inv);
        send_frame(inv, toggle, 1'b1);
        recv(stall_bin);
        for (int b = 0; b < PTS; b++) begin
            check($sformatf("%s_re%0d", tag, b), got_re[b], exp_re[b]);
            check($sformatf("%s_im%0d", tag, b), got_im[b], exp_im[b]);
        end
    endtask

    task automatic fill_random();
        for (int n = 0; n < PTS; n++) begin
            in_re[n] = int'($urandom_range(8000)) - 4000;
            in_im[n] = int'($urandom_range(8000)) - 4000;
        end
    endtask

    task automatic fill_impulse();
        for (int n = 0; n < PTS; n++) begin
            in_re[n] = (n == 0) ? 1000 : 0;
            in_im[n] = 0;
        end
    endtask

    initial begin
        int seen, g;
        rst = 1'b1; in_valid = 1'b0; in_real = '0; in_imag = '0;
        inverse = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        @(negedge clk);

        // Ramp, forward
        for (int n = 0; n < PTS; n++) begin in_re[n] = n * 256; in_im[n] = 0; end
        run_frame("ramp", 1'b0, 1'b0, -1);
`ifdef FFT_STAGE_SCALE_EN
        check("ramp_x0re", got_re[0], 896, 1);
        check("ramp_x0im", got_im[0], 0, 1);
        check("ramp_x4re", got_re[4], -128, 1);
        check("ramp_x4im", got_im[4], 0, 1);
`else
        check("ramp_x0re", got_re[0], 7168, 1);
        check("ramp_x0im", got_im[0], 0, 1);
        check("ramp_x2re", got_re[2], -1024, 1);
        check("ramp_x2im", got_im[2], 1024, 1);
        check("ramp_x4re", got_re[4], -1024, 1);
        check("ramp_x4im", got_im[4], 0, 1);
        check("ramp_x6re", got_re[6], -1024, 1);
        check("ramp_x6im", got_im[6], -1024, 1);
`endif

        // Impulse: flat spectrum
        fill_impulse();
        run_frame("imp", 1'b0, 1'b0, -1);
`ifdef FFT_STAGE_SCALE_EN
        g = 125;
`else
        g = 1000;
`endif
        for (int b = 0; b < PTS; b++) begin
            check($sformatf("imp_flat_re%0d", b), got_re[b], g, 1);
            check($sformatf("imp_flat_im%0d", b), got_im[b], 0, 1);
        end

        // Constant, inverse captured on sample 0 then toggled
        for (int n = 0; n < PTS; n++) begin in_re[n] = 100; in_im[n] = 0; end
        run_frame("cinv", 1'b1, 1'b1, -1);
`ifdef FFT_STAGE_SCALE_EN
        g = 100;
`else
        g = 800;
`endif
        check("cinv_x0re", got_re[0], g, 1);
        for (int b = 1; b < PTS; b++) check($sformatf("cinv_zero_re%0d", b), got_re[b], 0, 1);

        // Output stall at bin 3
        fill_random();
        run_frame("stall", 1'b0, 1'b0, 3);

        // Random frames, random direction, inverse toggling after sample 0
        for (int f = 0; f < 6; f++) begin
            fill_random();
            run_frame($sformatf("rnd%0d", f), 1'($urandom), 1'b1, -1);
        end

        // Reset during LOAD: next accepted sample is sample 0 again
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_real = 16'($urandom); in_imag = 16'($urandom);
            @(posedge clk); @(negedge clk);
        end
        pulse_reset("rst_load");
        for (int n = 0; n < PTS; n++) begin in_re[n] = n * 256; in_im[n] = 0; end
        run_frame("after_load_rst", 1'b0, 1'b0, -1);

        // Reset during COMPUTE: aborted frame never produces output
        fill_random();
        send_frame(1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        check("compute_busy", int'(busy), 1);
        pulse_reset("rst_compute");
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("abort_ov_count", seen, 0);
        fill_impulse();
        run_frame("after_comp_rst", 1'b0, 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
